// File: rtl/led_bar_meter.sv
// rtl/led_bar_meter.sv - multi-channel LED bar-graph driver with peak hold and decay
//
// Each channel scales a sampled level to a lit-LED count (thermometer code).
// It holds the highest bar as a single marker LED, then decays the marker one
// LED per step. All channels share one display-tick prescaler.
//
// Optional build macro: LED_BAR_BLINK_EN
//   When defined, a saturated bar blinks all-on/all-off once per tick.
//   When undefined, a saturated bar is steady all-on.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   level_valid  [NCH]          per-channel sample strobe
//   level        [NCH*LEVEL_W]  packed levels, ch0 in LSBs
//   led          [NCH*LEDS]     packed bars, ch0 in LSBs, bit0 = bottom LED
//   peak         [NCH*PW]       current peak-marker count per channel
//   tick         one-cycle display tick pulse

module led_bar_meter #(
  parameter int NCH         = 2,
  parameter int LEVEL_W     = 6,
  parameter int LEDS        = 8,
  parameter int SHIFT       = 1,
  parameter int TICK_DIV    = 1_000_000,
  parameter int HOLD_TICKS  = 8,
  parameter int DECAY_TICKS = 2,
  localparam int PW         = $clog2(LEDS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         level_valid,
  input  logic [NCH*LEVEL_W-1:0] level,
  output logic [NCH*LEDS-1:0]    led,
  output logic [NCH*PW-1:0]      peak,
  output logic                   tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int DW = (DECAY_TICKS > 0) ? $clog2(DECAY_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } state_t;

  // Shared display-tick prescaler; tick is decoded from the counter register.
  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef LED_BAR_BLINK_EN
  // Shared blink phase; starts "on" so a bar that saturates right after
  // reset is visible immediately.
  logic phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= 1'b1;
    end else if (tick) begin
      phase <= ~phase;
    end
  end
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [LEVEL_W-1:0] lvl_sh;
    logic [PW-1:0]      nbar;
    logic [PW-1:0]      bar_q;
    logic [PW-1:0]      peak_q;
    logic [PW-1:0]      peak_d;
    logic [HW-1:0]      hold_q;
    logic [HW-1:0]      hold_d;
    logic [DW-1:0]      decay_q;
    logic [DW-1:0]      decay_d;
    state_t             state_q;
    state_t             state_d;
    logic               grab;
    logic [LEDS-1:0]    bar_leds;

    assign lvl_sh = level[c*LEVEL_W +: LEVEL_W] >> SHIFT;
    assign nbar   = (int'(lvl_sh) > LEDS) ? PW'(LEDS) : PW'(lvl_sh);

    // A new sample at or above the marker (and non-empty) restarts the hold,
    // overriding whatever a same-cycle tick would have done.
    assign grab = level_valid[c] && (nbar >= peak_q) && (nbar != '0);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        bar_q   <= '0;
        peak_q  <= '0;
        hold_q  <= '0;
        decay_q <= '0;
        state_q <= IDLE;
      end else begin
        if (level_valid[c]) begin
          bar_q <= nbar;
        end
        peak_q  <= peak_d;
        hold_q  <= hold_d;
        decay_q <= decay_d;
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      peak_d  = peak_q;
      hold_d  = hold_q;
      decay_d = decay_q;
      if (grab) begin
        peak_d  = nbar;
        hold_d  = HW'(HOLD_TICKS);
        state_d = HOLD;
      end else begin
        case (state_q)
          IDLE: begin
            // Marker follows the bar; a lower sample is tracked right away so
            // no stale marker flashes for a cycle.
            peak_d = level_valid[c] ? nbar : bar_q;
          end
          HOLD: begin
            if (tick) begin
              if (hold_q <= HW'(1)) begin
                hold_d  = '0;
                decay_d = DW'(DECAY_TICKS);
                state_d = DECAY;
              end else begin
                hold_d = hold_q - 1'b1;
              end
            end
          end
          DECAY: begin
            if (tick) begin
              if (decay_q <= DW'(1)) begin
                if (peak_q > bar_q + PW'(1)) begin
                  peak_d  = peak_q - 1'b1;
                  decay_d = DW'(DECAY_TICKS);
                end else begin
                  peak_d  = bar_q;
                  decay_d = '0;
                  state_d = IDLE;
                end
              end else begin
                decay_d = decay_q - 1'b1;
              end
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end

    // Thermometer of bar_q plus the single marker LED at position peak_q-1
    // when the marker sits above the bar.
    always_comb begin
      bar_leds = '0;
      for (int i = 0; i < LEDS; i++) begin
        bar_leds[i] = (PW'(i) < bar_q) ||
                      ((peak_q > bar_q) && (PW'(i + 1) == peak_q));
      end
    end

`ifdef LED_BAR_BLINK_EN
    assign led[c*LEDS +: LEDS] = (bar_q == PW'(LEDS)) ? {LEDS{phase}} : bar_leds;
`else
    assign led[c*LEDS +: LEDS] = bar_leds;
`endif

    assign peak[c*PW +: PW] = peak_q;
  end

endmodule

// File: tb/tb_led_bar_meter.sv
// tb/tb_led_bar_meter.sv - self-checking bench for led_bar_meter

module tb_led_bar_meter;

  localparam int NCH         = 2;
  localparam int LEVEL_W     = 6;
  localparam int LEDS        = 8;
  localparam int SHIFT       = 1;
  localparam int TICK_DIV    = 4;
  localparam int HOLD_TICKS  = 2;
  localparam int DECAY_TICKS = 1;
  localparam int PW          = $clog2(LEDS + 1);

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NCH-1:0]         level_valid = '0;
  logic [NCH*LEVEL_W-1:0] level = '0;
  logic [NCH*LEDS-1:0]    led;
  logic [NCH*PW-1:0]      peak;
  logic                   tick;

  int checks = 0;
  int errors = 0;
  int mcnt = 0;
  bit last_tick = 1'b0;
  bit mphase = 1'b1;
  int exp_q[$];

  always #5 clk = ~clk;

  led_bar_meter #(
    .NCH(NCH), .LEVEL_W(LEVEL_W), .LEDS(LEDS), .SHIFT(SHIFT),
    .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS), .DECAY_TICKS(DECAY_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .level_valid(level_valid), .level(level),
    .led(led), .peak(peak), .tick(tick)
  );

  function automatic logic [7:0] therm(input int n);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < LEDS; i++) if (i < n) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] sat_leds();
`ifdef LED_BAR_BLINK_EN
    return mphase ? 8'hFF : 8'h00;
`else
    return 8'hFF;
`endif
  endfunction

  function automatic logic [7:0] bar_exp(input int n);
    if (n >= LEDS) return sat_leds();
    return therm(n);
  endfunction

  function automatic int sat(input int lv);
    int b;
    b = lv >> SHIFT;
    return (b > LEDS) ? LEDS : b;
  endfunction

  task automatic step();
    last_tick = (mcnt == TICK_DIV - 1);
    @(posedge clk);
    #1;
    mcnt = (mcnt + 1) % TICK_DIV;
    if (last_tick) mphase = ~mphase;
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    seen = 0;
    while (seen < n) begin
      step();
      if (last_tick) seen++;
    end
  endtask

  task automatic set_ch(input int ch, input int lv, input bit v);
    level[ch*LEVEL_W +: LEVEL_W] = LEVEL_W'(lv);
    level_valid[ch] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    level_valid = '0;
    level = '0;
    @(negedge clk);
    reset = 1'b1;
    mcnt = 0;
    mphase = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++; if (led !== '0) begin errors++; $display("FAIL reset_led: got %h expected 0", led); end
    checks++; if (peak !== '0) begin errors++; $display("FAIL reset_peak: got %h expected 0", peak); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
    @(negedge clk);
    reset = 1'b1;
    mcnt = 0;
    mphase = 1'b1;
  endtask

  task automatic test_sweep();
    int b;
    for (int lv = 0; lv < 64; lv++) begin
      set_ch(0, lv, 1'b1);
      exp_q.push_back(sat(lv));
      step();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sweep_queue: got empty expected entry lv=%0d", lv);
      end else begin
        b = exp_q.pop_front();
        if (led[7:0] !== bar_exp(b)) begin
          errors++; $display("FAIL sweep_led lv=%0d: got %h expected %h", lv, led[7:0], bar_exp(b));
        end
        checks++;
        if (peak[3:0] !== 4'(b)) begin
          errors++; $display("FAIL sweep_peak lv=%0d: got %0d expected %0d", lv, peak[3:0], b);
        end
      end
    end
    level_valid = '0;
  endtask

  task automatic test_peak_hold();
    logic [7:0] seq [8];
    seq = '{8'h23, 8'h23, 8'h23, 8'h13, 8'h0B, 8'h07, 8'h03, 8'h03};
    do_reset();
    set_ch(0, 12, 1'b1); step();
    set_ch(0, 4, 1'b1);  step();
    level_valid = '0;
    checks++; if (led[7:0] !== seq[0]) begin errors++; $display("FAIL hold_start: got %h expected %h", led[7:0], seq[0]); end
    checks++; if (peak[3:0] !== 4'd6) begin errors++; $display("FAIL hold_peak: got %0d expected 6", peak[3:0]); end
    for (int n = 1; n < 8; n++) begin
      wait_ticks(1);
      checks++;
      if (led[7:0] !== seq[n]) begin errors++; $display("FAIL hold_tick%0d: got %h expected %h", n, led[7:0], seq[n]); end
    end
    checks++; if (peak[3:0] !== 4'd2) begin errors++; $display("FAIL hold_end_peak: got %0d expected 2", peak[3:0]); end
  endtask

  task automatic test_collision();
    do_reset();
    set_ch(0, 12, 1'b1); step();
    set_ch(0, 4, 1'b1);  step();
    level_valid = '0;
    wait_ticks(3);
    checks++; if (led[7:0] !== 8'h13) begin errors++; $display("FAIL coll_decay: got %h expected 13", led[7:0]); end
    while (mcnt != TICK_DIV - 1) step();
    set_ch(0, 14, 1'b1); step();
    checks++; if (!last_tick) begin errors++; $display("FAIL coll_align: got no tick expected tick edge"); end
    checks++; if (peak[3:0] !== 4'd7) begin errors++; $display("FAIL coll_peak: got %0d expected 7", peak[3:0]); end
    checks++; if (led[7:0] !== 8'h7F) begin errors++; $display("FAIL coll_led: got %h expected 7f", led[7:0]); end
    set_ch(0, 4, 1'b1); step();
    level_valid = '0;
    checks++; if (led[7:0] !== 8'h43) begin errors++; $display("FAIL coll_marker: got %h expected 43", led[7:0]); end
    wait_ticks(1);
    checks++; if (led[7:0] !== 8'h43) begin errors++; $display("FAIL coll_tick1: got %h expected 43", led[7:0]); end
    wait_ticks(1);
    checks++; if (led[7:0] !== 8'h43) begin errors++; $display("FAIL coll_tick2: got %h expected 43", led[7:0]); end
    wait_ticks(1);
    checks++; if (led[7:0] !== 8'h23) begin errors++; $display("FAIL coll_tick3: got %h expected 23", led[7:0]); end
  endtask

  task automatic test_independence();
    int lvs [3];
    logic [7:0] exp0 [3];
    lvs  = '{6, 10, 2};
    exp0 = '{8'h07, 8'h1F, 8'h11};
    do_reset();
    set_ch(1, 63, 1'b1);
    set_ch(0, 0, 1'b1);
    step();
    checks++; if (led !== {sat_leds(), 8'h00}) begin errors++; $display("FAIL indep_init: got %h expected %h", led, {sat_leds(), 8'h00}); end
    level_valid[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_ch(0, lvs[k], 1'b1);
      step();
      checks++; if (led[7:0] !== exp0[k]) begin errors++; $display("FAIL indep_ch0_%0d: got %h expected %h", k, led[7:0], exp0[k]); end
      checks++; if (led[15:8] !== sat_leds()) begin errors++; $display("FAIL indep_ch1_%0d: got %h expected %h", k, led[15:8], sat_leds()); end
      checks++; if (peak[7:4] !== 4'd8) begin errors++; $display("FAIL indep_peak1_%0d: got %0d expected 8", k, peak[7:4]); end
    end
    level_valid = '0;
  endtask

  task automatic test_blink();
    for (int n = 0; n < 4; n++) begin
      wait_ticks(1);
      checks++; if (led[15:8] !== sat_leds()) begin errors++; $display("FAIL blink_tick%0d: got %h expected %h", n, led[15:8], sat_leds()); end
      checks++; if (peak[7:4] !== 4'd8) begin errors++; $display("FAIL blink_peak%0d: got %0d expected 8", n, peak[7:4]); end
    end
  endtask

  task automatic test_async_reset();
    logic exp_t [3];
    exp_t = '{1'b0, 1'b0, 1'b1};
    do_reset();
    set_ch(0, 12, 1'b1); step();
    set_ch(0, 4, 1'b1);  step();
    level_valid = '0;
    wait_ticks(3);
    while (mcnt != TICK_DIV - 1) step();
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL ares_pre_tick: got %b expected 1", tick); end
    #2 reset = 1'b0;
    #1;
    checks++; if (led !== '0) begin errors++; $display("FAIL ares_led: got %h expected 0", led); end
    checks++; if (peak !== '0) begin errors++; $display("FAIL ares_peak: got %h expected 0", peak); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL ares_tick: got %b expected 0", tick); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    mcnt = 0;
    mphase = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      checks++; if (tick !== exp_t[e]) begin errors++; $display("FAIL ares_tick_edge%0d: got %b expected %b", e + 1, tick, exp_t[e]); end
    end
    checks++; if (led !== '0) begin errors++; $display("FAIL ares_led_after: got %h expected 0", led); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_peak_hold();
    test_collision();
    test_independence();
    test_blink();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
